// File: rtl/bloonstd1_soc_keys_pio.sv
// Avalon-MM input PIO for the board keys: synchronized data register,
// sticky per-bit edge capture and a masked level interrupt.

module bloonstd1_soc_keys_pio_lane #(
    parameter int   EDGE_TYPE = 1,
    parameter logic RST_VAL   = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic in_bit,
    input  logic clr,
    output logic data,
    output logic cap
);
    logic sync1, sync2, prev, edge_det;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= RST_VAL;
            sync2 <= RST_VAL;
            prev  <= RST_VAL;
            cap   <= 1'b0;
        end else begin
            sync1 <= in_bit;
            sync2 <= sync1;
            prev  <= sync2;
            // a fresh edge overrides a same-cycle write-1-to-clear
            cap   <= (cap & ~clr) | edge_det;
        end
    end

    always_comb begin
        edge_det = 1'b0;
        case (EDGE_TYPE)
            0:       edge_det = sync2 & ~prev;
            1:       edge_det = ~sync2 & prev;
            default: edge_det = sync2 ^ prev;
        endcase
    end

    assign data = sync2;
endmodule

module bloonstd1_soc_keys_pio #(
    parameter int               WIDTH        = 4,
    parameter int               EDGE_TYPE    = 1,
    parameter logic [WIDTH-1:0] IN_RESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic             wr_en;
    logic [WIDTH-1:0] clr, data, edge_capture, irq_mask;
    logic             unused_wdata;

    assign wr_en = chipselect & ~write_n;
    assign clr   = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    // bits above WIDTH have no register behind them
    assign unused_wdata = ^writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        bloonstd1_soc_keys_pio_lane #(
            .EDGE_TYPE(EDGE_TYPE),
            .RST_VAL  (IN_RESET_VAL[i])
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .in_bit(in_port[i]),
            .clr   (clr[i]),
            .data  (data[i]),
            .cap   (edge_capture[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            irq_mask <= '0;
        else if (wr_en && address == 2'd2)
            irq_mask <= writedata[WIDTH-1:0];
    end

    assign irq = |(edge_capture & irq_mask);

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = data;
            2'd2:    readdata[WIDTH-1:0] = irq_mask;
            2'd3:    readdata[WIDTH-1:0] = edge_capture;
            default: readdata = '0;
        endcase
    end
endmodule

// File: tb/tb_bloonstd1_soc_keys_pio.sv
// Bench for the keys PIO: directed vector table, a second instance in
// any-edge mode for toggle/reset cases, then random traffic vs a history model.

module tb_bloonstd1_soc_keys_pio;
    logic        clk = 1'b0;
    logic        reset, reset_b;
    logic [1:0]  address, address_b;
    logic        chipselect, chipselect_b, write_n, write_n_b;
    logic [31:0] writedata, writedata_b, readdata, readdata_b;
    logic [3:0]  in_port, in_port_b;
    logic        irq, irq_b;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    bloonstd1_soc_keys_pio dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    bloonstd1_soc_keys_pio #(.WIDTH(4), .EDGE_TYPE(2), .IN_RESET_VAL(4'h0)) dut_b (
        .clk(clk), .reset(reset_b), .address(address_b), .chipselect(chipselect_b),
        .write_n(write_n_b), .writedata(writedata_b), .in_port(in_port_b),
        .readdata(readdata_b), .irq(irq_b)
    );

    // Reference for dut: the key samples taken at the last three clock edges
    // (oldest first), plus the sticky capture and mask words.
    logic [3:0] hist[$];
    logic [3:0] m_cap, m_mask;

    task automatic model_reset();
        hist = {4'hF, 4'hF, 4'hF};
        m_cap = 4'h0;
        m_mask = 4'h0;
    endtask

    task automatic model_edge();
        logic [3:0] older, newer, fell, clr;
        older = hist[0];
        newer = hist[1];
        fell = older & ~newer;
        clr = (chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0;
        m_cap = (m_cap & ~clr) | fell;
        if (chipselect && !write_n && address == 2'd2) m_mask = writedata[3:0];
        hist.push_back(in_port);
        hist.delete(0);
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'h0, hist[1]};
            2'd2:    return {28'h0, m_mask};
            2'd3:    return {28'h0, m_cap};
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_edge();
        @(negedge clk);
    endtask

    typedef struct packed {
        logic [3:0]  in;
        logic [1:0]  addr;
        logic        cs;
        logic        wr_n;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        irq;
    } vec_t;

    vec_t tbl[32];

    task automatic bus_b(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd);
        address_b = a; chipselect_b = cs; write_n_b = wn; writedata_b = wd;
    endtask

    initial begin
        tbl[0]  = '{4'hE, 2'd0, 1'b0, 1'b1, 32'h0, 32'hF, 1'b0};
        tbl[1]  = '{4'hE, 2'd0, 1'b0, 1'b1, 32'h0, 32'hE, 1'b0};
        tbl[2]  = '{4'hE, 2'd3, 1'b0, 1'b1, 32'h0, 32'h1, 1'b0};
        tbl[3]  = '{4'hE, 2'd3, 1'b0, 1'b1, 32'h0, 32'h1, 1'b0};
        tbl[4]  = '{4'hE, 2'd3, 1'b1, 1'b0, 32'h1, 32'h0, 1'b0};
        tbl[5]  = '{4'hE, 2'd2, 1'b1, 1'b0, 32'h1, 32'h1, 1'b0};
        tbl[6]  = '{4'hF, 2'd3, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0};
        tbl[7]  = '{4'hF, 2'd3, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0};
        tbl[8]  = '{4'hF, 2'd3, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0};
        tbl[9]  = '{4'hE, 2'd3, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0};
        tbl[10] = '{4'hE, 2'd0, 1'b0, 1'b1, 32'h0, 32'hE, 1'b0};
        tbl[11] = '{4'hE, 2'd3, 1'b0, 1'b1, 32'h0, 32'h1, 1'b1};
        tbl[12] = '{4'hE, 2'd3, 1'b1, 1'b0, 32'h1, 32'h0, 1'b0};
        tbl[13] = '{4'hF, 2'd3, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0};
        tbl[14] = '{4'hF, 2'd3, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0};
        tbl[15] = '{4'hE, 2'd3, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0};
        tbl[16] = '{4'hE, 2'd3, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0};
        tbl[17] = '{4'hE, 2'd3, 1'b1, 1'b0, 32'h1, 32'h1, 1'b1};
        tbl[18] = '{4'hE, 2'd3, 1'b0, 1'b1, 32'h0, 32'h1, 1'b1};
        tbl[19] = '{4'hE, 2'd3, 1'b1, 1'b0, 32'h1, 32'h0, 1'b0};
        tbl[20] = '{4'hF, 2'd3, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0};
        tbl[21] = '{4'hF, 2'd3, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0};
        tbl[22] = '{4'hF, 2'd3, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0};
        tbl[23] = '{4'h5, 2'd3, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0};
        tbl[24] = '{4'h5, 2'd0, 1'b0, 1'b1, 32'h0, 32'h5, 1'b0};
        tbl[25] = '{4'h5, 2'd3, 1'b0, 1'b1, 32'h0, 32'hA, 1'b0};
        tbl[26] = '{4'h5, 2'd3, 1'b1, 1'b0, 32'h8, 32'h2, 1'b0};
        tbl[27] = '{4'h5, 2'd3, 1'b0, 1'b0, 32'hF, 32'h2, 1'b0};
        tbl[28] = '{4'h5, 2'd2, 1'b0, 1'b0, 32'hF, 32'h1, 1'b0};
        tbl[29] = '{4'h5, 2'd1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b0};
        tbl[30] = '{4'h5, 2'd0, 1'b1, 1'b0, 32'h0, 32'h5, 1'b0};
        tbl[31] = '{4'h5, 2'd2, 1'b1, 1'b0, 32'h2, 32'h2, 1'b1};

        reset = 1'b1; reset_b = 1'b1;
        address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
        in_port = 4'hF; in_port_b = 4'h0;
        bus_b(2'd0, 1'b0, 1'b1, 32'h0);
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        chk("reset_data", readdata, 32'hF);
        reset = 1'b0; reset_b = 1'b0;

        repeat (10) tick();
        chk("idle_data", readdata, 32'hF);
        address = 2'd3;
        #1 chk("idle_capture", readdata, 32'h0);
        chk("idle_irq", {31'h0, irq}, 32'h0);
        @(negedge clk);

        for (int i = 0; i < 32; i++) begin
            in_port = tbl[i].in; address = tbl[i].addr; chipselect = tbl[i].cs;
            write_n = tbl[i].wr_n; writedata = tbl[i].wd;
            tick();
            chk($sformatf("vec%0d_rd", i), readdata, tbl[i].rd);
            chk($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, tbl[i].irq});
        end
        chipselect = 1'b0; write_n = 1'b1;

        // any-edge instance: bit2 rises then falls, each held five cycles
        repeat (3) tick();
        bus_b(2'd2, 1'b1, 1'b0, 32'h4);
        tick();
        for (int t = 0; t < 2; t++) begin
            in_port_b = (t == 0) ? 4'h4 : 4'h0;
            bus_b(2'd3, 1'b0, 1'b1, 32'h0);
            tick(); tick();
            chk($sformatf("b_pre%0d", t), readdata_b, 32'h0);
            tick();
            chk($sformatf("b_cap%0d", t), readdata_b, 32'h4);
            chk($sformatf("b_irq%0d", t), {31'h0, irq_b}, 32'h1);
            bus_b(2'd3, 1'b1, 1'b0, 32'h4);
            tick();
            chk($sformatf("b_clr%0d", t), readdata_b, 32'h0);
            chk($sformatf("b_clr_irq%0d", t), {31'h0, irq_b}, 32'h0);
            bus_b(2'd3, 1'b0, 1'b1, 32'h0);
            tick();
            chk($sformatf("b_once%0d", t), readdata_b, 32'h0);
        end
        in_port_b = 4'h4;
        repeat (3) tick();
        chk("b_cap_pre_rst", readdata_b, 32'h4);
        reset_b = 1'b1;
        #1 chk("b_rst_cap", readdata_b, 32'h0);
        chk("b_rst_irq", {31'h0, irq_b}, 32'h0);
        address_b = 2'd2;
        #1 chk("b_rst_mask", readdata_b, 32'h0);
        address_b = 2'd0;
        #1 chk("b_rst_data", readdata_b, 32'h0);
        in_port_b = 4'h0;
        @(negedge clk);
        reset_b = 1'b0;
        address_b = 2'd3;
        repeat (5) tick();
        chk("b_no_spurious", readdata_b, 32'h0);

        // random traffic against the history model, with one mid-run reset
        begin
            int hold;
            hold = 0;
            for (int c = 0; c < 400; c++) begin
                if (hold == 0) begin
                    in_port = 4'($urandom);
                    hold = int'($urandom_range(1, 4));
                end
                hold--;
                address = 2'($urandom);
                chipselect = ($urandom_range(0, 3) != 0);
                write_n = ($urandom_range(0, 2) != 0);
                writedata = $urandom;
                if (c == 200) begin
                    reset = 1'b1;
                    model_reset();
                    #1 chk("rnd_rst_irq", {31'h0, irq}, 32'h0);
                    chk("rnd_rst_rd", readdata, model_read(address));
                    @(negedge clk);
                    reset = 1'b0;
                end
                tick();
                chk($sformatf("rnd%0d_rd", c), readdata, model_read(address));
                chk($sformatf("rnd%0d_irq", c), {31'h0, irq}, {31'h0, |(m_cap & m_mask)});
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
